// File: rtl/car_pkg.sv
// car_pkg: shared encodings and widths for the player-car logic.
// car_move command codes, car_mover state encoding, position width and a
// saturating 8-bit increment helper.
package car_pkg;

    // Position width on the car_x port; comparisons use one extra bit so
    // X_MIN - STEP or X_MAX + STEP never wraps.
    localparam int X_W     = 10;
    localparam int X_CMP_W = X_W + 1;

    typedef enum logic [1:0] {
        MOVE_IDLE    = 2'b00,
        MOVE_LEFT    = 2'b01,
        MOVE_RIGHT   = 2'b10,
        MOVE_COLLIDE = 2'b11
    } car_move_t;

    typedef enum logic [1:0] {
        DRIVE   = 2'b00,
        CRASH   = 2'b01,
        RECOVER = 2'b10
    } car_state_t;

    // Crash counter increments but sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running 0..TICK_DIV-1 counter with a one-cycle tick
// while the count sits at TICK_DIV-1. Shared by movement and scroll logic.
module tick_divider #(
    parameter int TICK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_reg;

    // Count up, wrapping to zero after the tick cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/car_mover.sv
// car_mover: owns the player car's horizontal position.
// Steps car_x by STEP on each movement tick under car_move, clamps at the
// road edges and holds collision high through a crash sequence.
// Optional feature macro CAR_RECENTER_EN: after the crash hold the car walks
// back to X_START (RECOVER) before driving resumes; without it the car
// resumes driving from where it crashed.
module car_mover
    import car_pkg::*;
#(
    parameter int TICK_DIV      = 2_500_000,
    parameter int STEP          = 2,
    parameter int X_MIN         = 200,
    parameter int X_MAX         = 420,
    parameter int X_START       = 310,
    parameter int RECOVER_TICKS = 50
) (
    input  logic           clk,
    input  logic           btnC,
    input  logic [1:0]     car_move,
    input  logic           obstacle_hit,
    output logic [X_W-1:0] car_x,
    output logic           collision,
    output logic [7:0]     crash_count
);

    localparam int REC_W = (RECOVER_TICKS > 1) ? $clog2(RECOVER_TICKS) : 1;

    localparam logic [X_W-1:0]     X_MIN_X      = X_W'(X_MIN);
    localparam logic [X_W-1:0]     X_MAX_X      = X_W'(X_MAX);
    localparam logic [X_W-1:0]     X_START_X    = X_W'(X_START);
    localparam logic [X_CMP_W-1:0] STEP_C       = X_CMP_W'(STEP);
    localparam logic [X_CMP_W-1:0] X_MAX_C      = X_CMP_W'(X_MAX);
    localparam logic [X_CMP_W-1:0] X_MIN_STEP_C = X_CMP_W'(X_MIN + STEP);
    localparam logic [REC_W-1:0]   REC_LOAD     = REC_W'(RECOVER_TICKS - 1);

    logic tick;

    car_state_t       state_reg, state_next;
    logic [X_W-1:0]   x_reg, x_next;
    logic [REC_W-1:0] rec_reg, rec_next;
    logic [7:0]       crash_cnt_reg, crash_cnt_next;
    logic             collision_reg;

    logic [X_CMP_W-1:0] x_wide;
    logic [X_W-1:0]     x_step;
    logic               edge_hit;

    assign x_wide = {1'b0, x_reg};

`ifdef CAR_RECENTER_EN
    localparam logic [X_CMP_W-1:0] X_START_C = X_CMP_W'(X_START);

    // Distance from the recenter target, in either direction.
    logic [X_CMP_W-1:0] dist_to_start;
    assign dist_to_start = (x_wide > X_START_C) ? (x_wide - X_START_C)
                                                : (X_START_C - x_wide);
`endif

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (btnC),
        .tick (tick)
    );

    // State, position, recovery and crash-count registers.
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            state_reg     <= DRIVE;
            x_reg         <= X_START_X;
            rec_reg       <= '0;
            crash_cnt_reg <= '0;
            collision_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            rec_reg       <= rec_next;
            crash_cnt_reg <= crash_cnt_next;
            collision_reg <= (state_next != DRIVE);
        end
    end

    // Next-state, movement, clamping and crash bookkeeping.
    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        rec_next       = rec_reg;
        crash_cnt_next = crash_cnt_reg;
        x_step         = x_reg;
        edge_hit       = 1'b0;

        case (state_reg)
            DRIVE: begin
                if (tick) begin
                    case (car_move_t'(car_move))
                        MOVE_LEFT: begin
                            if (x_wide < X_MIN_STEP_C) begin
                                x_step   = X_MIN_X;
                                edge_hit = 1'b1;
                            end else begin
                                x_step = X_W'(x_wide - STEP_C);
                            end
                        end
                        MOVE_RIGHT: begin
                            if ((x_wide + STEP_C) > X_MAX_C) begin
                                x_step   = X_MAX_X;
                                edge_hit = 1'b1;
                            end else begin
                                x_step = X_W'(x_wide + STEP_C);
                            end
                        end
                        default: x_step = x_reg;
                    endcase
                end

                // An obstacle freezes the car where it is, but an edge
                // strike on the same tick still applies its clamp.
                if (edge_hit || !obstacle_hit) begin
                    x_next = x_step;
                end

                if (edge_hit || obstacle_hit) begin
                    state_next     = CRASH;
                    rec_next       = REC_LOAD;
                    crash_cnt_next = sat_inc8(crash_cnt_reg);
                end
            end

            CRASH: begin
                if (tick) begin
                    if (rec_reg == '0) begin
`ifdef CAR_RECENTER_EN
                        state_next = RECOVER;
`else
                        state_next = DRIVE;
`endif
                    end else begin
                        rec_next = rec_reg - REC_W'(1);
                    end
                end
            end

`ifdef CAR_RECENTER_EN
            RECOVER: begin
                if (tick) begin
                    if (dist_to_start <= STEP_C) begin
                        x_next     = X_START_X;
                        state_next = DRIVE;
                    end else if (x_wide < X_START_C) begin
                        x_next = X_W'(x_wide + STEP_C);
                    end else begin
                        x_next = X_W'(x_wide - STEP_C);
                    end
                end
            end
`endif

            default: state_next = DRIVE;
        endcase
    end

    assign car_x       = x_reg;
    assign collision   = collision_reg;
    assign crash_count = crash_cnt_reg;

endmodule

// File: tb/tb_car_mover.sv
// tb_car_mover: directed test of car_mover with TICK_DIV=4, STEP=2,
// X_MIN=100, X_MAX=200, X_START=150, RECOVER_TICKS=3.
// Stimulus pushes every expected output change (edge number after reset
// release, car_x, collision, crash_count) into a queue; a monitor on the
// falling edge pops one entry each time the outputs change and compares.
module tb_car_mover;

    logic       clk;
    logic       btnC;
    logic [1:0] car_move;
    logic       obstacle_hit;
    logic [9:0] car_x;
    logic       collision;
    logic [7:0] crash_count;

    typedef struct {
        int at_edge;
        int x;
        int coll;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    int  edge_no;
    int  n_tests;
    int  n_fail;

    car_mover #(
        .TICK_DIV      (4),
        .STEP          (2),
        .X_MIN         (100),
        .X_MAX         (200),
        .X_START       (150),
        .RECOVER_TICKS (3)
    ) dut (
        .clk          (clk),
        .btnC         (btnC),
        .car_move     (car_move),
        .obstacle_hit (obstacle_hit),
        .car_x        (car_x),
        .collision    (collision),
        .crash_count  (crash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; tick edges fall on multiples of 4.
    initial begin
        edge_no = 0;
        forever begin
            @(posedge clk);
            if (btnC) edge_no = 0;
            else      edge_no = edge_no + 1;
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_tests++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end else begin
            $display("[TB] ok   %s = %0d", name, got);
        end
    endtask

    task automatic push(input int e, input int x, input int c, input int n);
        ev_t ev;
        ev.at_edge = e;
        ev.x       = x;
        ev.coll    = c;
        ev.cnt     = n;
        exp_q.push_back(ev);
    endtask

    // Drive point: 2 time units after the rising edge numbered n.
    task automatic wait_edge(input int n);
        while (edge_no < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor: every output change must match the next queued expectation.
    initial begin
        int   px, pc, pn;
        ev_t  ev;
        px = -1; pc = -1; pn = -1;
        forever begin
            @(negedge clk);
            if (!btnC && (int'(car_x) != px || int'(collision) != pc ||
                          int'(crash_count) != pn)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_change at edge %0d: got x=%0d coll=%0d cnt=%0d, required no change",
                             edge_no, car_x, collision, crash_count);
                end else begin
                    ev = exp_q.pop_front();
                    n_tests++;
                    if (edge_no != ev.at_edge || int'(car_x) != ev.x ||
                        int'(collision) != ev.coll || int'(crash_count) != ev.cnt) begin
                        n_fail++;
                        $display("FAIL change_event: got edge=%0d x=%0d coll=%0d cnt=%0d, required edge=%0d x=%0d coll=%0d cnt=%0d",
                                 edge_no, car_x, collision, crash_count,
                                 ev.at_edge, ev.x, ev.coll, ev.cnt);
                    end else begin
                        $display("[TB] ok   edge=%0d x=%0d coll=%0d cnt=%0d",
                                 edge_no, car_x, collision, crash_count);
                    end
                end
            end
            px = int'(car_x);
            pc = int'(collision);
            pn = int'(crash_count);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t3, x0, n, e, t4, x4, t5, m, c;
        n_tests      = 0;
        n_fail       = 0;
        btnC         = 1'b1;
        car_move     = 2'b00;
        obstacle_hit = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        btnC     = 1'b0;
        car_move = 2'b01;
        #1;
        check("reset_car_x", int'(car_x), 150);
        check("reset_collision", int'(collision), 0);
        check("reset_crash_count", int'(crash_count), 0);

        // Tests 1-3: drive left into the edge, then the crash sequence
        for (int k = 1; k <= 25; k++) push(4 * k, 150 - 2 * k, 0, 0);
        push(104, 100, 1, 1);
`ifdef CAR_RECENTER_EN
        for (int j = 1; j <= 24; j++) push(116 + 4 * j, 100 + 2 * j, 1, 1);
        push(216, 150, 0, 1);
        t3 = 216;
        x0 = 150;
`else
        push(116, 100, 0, 1);
        t3 = 116;
        x0 = 100;
`endif
        wait_edge(105);
        car_move = 2'b00;

        // Test 4: drive right to 160, obstacle pulse, second pulse in CRASH
        n = (160 - x0) / 2;
        e = t3 + 4 * n;
        for (int k = 1; k <= n; k++) push(t3 + 4 * k, x0 + 2 * k, 0, 1);
        push(e + 2, 160, 1, 2);
`ifdef CAR_RECENTER_EN
        for (int j = 1; j <= 4; j++) push(e + 12 + 4 * j, 160 - 2 * j, 1, 2);
        push(e + 32, 150, 0, 2);
        t4 = e + 32;
        x4 = 150;
`else
        push(e + 12, 160, 0, 2);
        t4 = e + 12;
        x4 = 160;
`endif
        wait_edge(t3 + 1);
        car_move = 2'b10;
        wait_edge(e + 1);
        obstacle_hit = 1'b1;
        wait_edge(e + 2);
        obstacle_hit = 1'b0;
        car_move     = 2'b00;
        wait_edge(e + 5);
        obstacle_hit = 1'b1;
        wait_edge(e + 6);
        obstacle_hit = 1'b0;

        // Test 5: collide then idle commands leave the car in place
        wait_edge(t4 + 1);
        car_move = 2'b11;
        wait_edge(t4 + 17);
        car_move = 2'b00;
        wait_edge(t4 + 33);
        check("t5_events_pending", exp_q.size(), 0);
        check("t5_car_x", int'(car_x), x4);
        check("t5_collision", int'(collision), 0);
        t5 = t4 + 32;

        // Test 6: crash at the left edge again, reset mid-sequence
        m = (x4 - 100) / 2;
        c = t5 + 4 * (m + 1);
        for (int k = 1; k <= m; k++) push(t5 + 4 * k, x4 - 2 * k, 0, 2);
        push(c, 100, 1, 3);
`ifdef CAR_RECENTER_EN
        for (int j = 1; j <= 10; j++) push(c + 12 + 4 * j, 100 + 2 * j, 1, 3);
`endif
        car_move = 2'b01;
        wait_edge(c + 1);
        car_move = 2'b00;
`ifdef CAR_RECENTER_EN
        wait_edge(c + 53);
        check("t6_x_before_reset", int'(car_x), 120);
`else
        wait_edge(c + 6);
        check("t6_x_before_reset", int'(car_x), 100);
`endif
        check("t6_events_pending", exp_q.size(), 0);
        btnC = 1'b1;
        #1;
        check("t6_async_car_x", int'(car_x), 150);
        check("t6_async_collision", int'(collision), 0);
        check("t6_async_crash_count", int'(crash_count), 0);

        // Idle after reset release: nothing may move
        repeat (2) @(posedge clk);
        #2;
        btnC = 1'b0;
        wait_edge(12);
        check("final_events_pending", exp_q.size(), 0);
        check("final_car_x", int'(car_x), 150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/car_mover.md
# car_mover

Consumes the 2-bit `car_move` command from the car control FSM and owns the player car's horizontal position. It steps `car_x` at a fixed tick rate and clamps the car at the road edges. Edge strikes and obstacle hits raise `collision`, which feeds back to the control FSM. The block holds `collision` through a crash/recovery sequence and releases it when the car is drivable again.

## Interface
Parameters:
- `TICK_DIV`, 2_500_000 — clk cycles per movement tick (≥2)
- `STEP`, 2 — pixels moved per tick
- `X_MIN`, 200 — leftmost legal `car_x`
- `X_MAX`, 420 — rightmost legal `car_x`
- `X_START`, 310 — reset/recenter position; X_MIN+STEP ≤ X_START ≤ X_MAX−STEP
- `RECOVER_TICKS`, 50 — ticks spent in CRASH (≥1)

Ports:
- `clk` in 1 — system clock
- `btnC` in 1 — reset; one clock, reset asynchronous and active-high
- `car_move` in 2 — 00 idle, 01 left, 10 right, 11 collide (treated as idle)
- `obstacle_hit` in 1 — level/pulse from renderer overlap check
- `car_x` out 10 — car left-edge x position
- `collision` out 1 — high while in CRASH or RECOVER
- `crash_count` out 8 — crashes since reset, saturating

## Operation
- Tick: free-running counter 0..TICK_DIV−1. `tick` is high for one cycle when count = TICK_DIV−1, then the counter wraps to 0. The counter runs in all states.
- States: DRIVE, CRASH, RECOVER.
- DRIVE on tick:
  - 01: if car_x < X_MIN+STEP, car_x←X_MIN and go to CRASH; else car_x←car_x−STEP.
  - 10: if car_x+STEP > X_MAX, car_x←X_MAX and go to CRASH; else car_x←car_x+STEP.
  - 00/11: hold.
- DRIVE, any cycle: obstacle_hit=1 sends the block to CRASH with car_x unchanged that cycle.
- An edge strike and obstacle_hit on the same tick cause one CRASH entry, the clamp is applied, and crash_count increments once.
- CRASH entry: recovery counter←RECOVER_TICKS−1 and crash_count←min(crash_count+1,255).
- CRASH on tick: if the counter is 0, leave (see Configuration); else decrement.
- RECOVER on tick:
  - If |X_START−car_x| ≤ STEP, car_x←X_START and go to DRIVE.
  - Otherwise step STEP toward X_START.
- CRASH/RECOVER ignore car_move and obstacle_hit.
- Arithmetic: unsigned, compared in 11 bits so no wrap below 0 or above 1023.

## Timing
- Reset (async, immediate): car_x=X_START, state DRIVE, collision=0, crash_count=0, tick counter=0, recovery counter=0.
- Deassertion takes effect at the next clk edge.
- `car_x`, `collision` and `crash_count` are registered.
- `collision` = (state≠DRIVE), decoded from the state register. It rises in the cycle after the triggering tick or obstacle_hit cycle.
- Position latency: car_x changes in the cycle after tick.
- CRASH lasts exactly RECOVER_TICKS ticks, counting the first tick after entry.
- `collision` falls in the same cycle the state returns to DRIVE.
- btnC asserted mid-CRASH/RECOVER aborts immediately to reset values.

## Configuration
- `CAR_RECENTER_EN` defined: CRASH exits to RECOVER, and the car walks back to X_START with collision held.
- Undefined: RECOVER is not compiled. CRASH exits directly to DRIVE with car_x left at its crash position (clamped edge or obstacle spot).

## Structure
- Package `car_pkg`:
  - car_move encodings MOVE_IDLE/MOVE_LEFT/MOVE_RIGHT/MOVE_COLLIDE
  - state encoding typedef (DRIVE/CRASH/RECOVER)
  - X_W=10 width constant
- Sub-module `tick_divider` (parameter TICK_DIV, outputs `tick`), reused by the scroll logic.

## Test plan
Settings: TICK_DIV=4, STEP=2, X_MIN=100, X_MAX=200, X_START=150, RECOVER_TICKS=3.
1. Reset, then car_move=01 for 10 ticks -> car_x 150→130, one 2-pixel step every 4 cycles, collision stays 0.
2. Hold 01 for 26 ticks -> x=100 after tick 25; tick 26 keeps x=100, collision=1, crash_count=1.
3. With CAR_RECENTER_EN, after test 2 -> collision high for 3 CRASH ticks + 25 RECOVER ticks, car_x climbs to 150, collision falls as car_x hits 150. Without the macro -> collision falls after 3 ticks, car_x=100.
4. car_move=10, single obstacle_hit pulse between ticks at x=160 -> collision next cycle, car_x=160, crash_count+1. A second obstacle_hit during CRASH -> count unchanged.
5. car_move=11 then 00 for 8 ticks in DRIVE -> car_x unchanged, collision 0.
6. btnC pulse mid-RECOVER at x=120 -> car_x=150, collision=0, crash_count=0 without waiting for a clk edge.
